// File: rtl/mem_stream_reader.sv
// Streams a burst of count+1 words from a combinational-read memory onto a valid/ready port.
// Define MEM_STREAM_READER_CHECKSUM_EN to append an XOR checksum beat to every burst.
module mem_stream_reader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              busy,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              done
);

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, RUN, CSUM, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    // A new beat may be loaded when the output slot is empty or being drained this cycle.
    logic load;
    assign load = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
            RUN:     if (load && remaining_q == '0) state_d = CSUM;
            CSUM:    if (load) state_d = DRAIN;
`else
            RUN:     if (load && remaining_q == '0) state_d = DRAIN;
`endif
            DRAIN:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = start_addr;
                    remaining_d = count;
                    busy_d      = 1'b1;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            RUN: begin
                if (load) begin
                    out_data_d  = r_data;
                    out_valid_d = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
                    out_last_d  = 1'b0;
                    csum_d      = csum_q ^ r_data;
`else
                    out_last_d  = (remaining_q == '0);
`endif
                end
            end
`ifdef MEM_STREAM_READER_CHECKSUM_EN
            CSUM: begin
                if (load) begin
                    out_data_d  = csum_q;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                end
            end
`endif
            DRAIN: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = busy_q;
        r_addr    = addr_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_last  = out_last_q;
        done      = done_q;
    end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter: DATA_W, 16, data word width.
REQ-002 Parameter: ADDR_W, 3, memory address width; memory depth is 2**ADDR_W (8).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  command strobe, sampled only while busy=0.
REQ-007 start_addr  in  ADDR_W  first memory address to read.
REQ-008 count  in  ADDR_W  beats minus one; burst length is count+1, range 1..8.
REQ-009 busy  out  1  high from command accept until the done pulse.
REQ-010 r_addr  out  ADDR_W  read address to the memory's combinational read port.
REQ-011 r_data  in  DATA_W  memory word at r_addr, valid in the same cycle.
REQ-012 out_valid  out  1  stream beat valid.
REQ-013 out_data  out  DATA_W  stream beat payload.
REQ-014 out_last  out  1  marks the final beat of a burst.
REQ-015 out_ready  in  1  downstream accepts the beat when out_valid=1 and out_ready=1.
REQ-016 done  out  1  one-cycle pulse after the final beat is accepted.

Function
REQ-017 FSM states: IDLE, RUN, CSUM (checksum beat; built only with CHECKSUM_EN), DRAIN.
REQ-018 IDLE + start=1 at an edge: latch addr<=start_addr and remaining<=count, then go to RUN with busy=1.
REQ-019 start while busy=1 is ignored and has no side effects.
REQ-020 r_addr is driven directly from the internal address register.
REQ-021 RUN, load condition (out_valid=0 or out_ready=1): out_data<=r_data; out_valid<=1; addr<=addr+1 modulo 8; remaining<=remaining-1.
REQ-022 Address wrap: 7 is followed by 0 (start_addr=6, count=3 reads 6,7,0,1).
REQ-023 RUN, load of the beat with remaining=0: without CHECKSUM_EN set out_last=1 and go to DRAIN; with CHECKSUM_EN go to CSUM.
REQ-024 out_data, out_last and out_valid hold stable while out_valid=1 and out_ready=0.
REQ-025 Latency: start sampled at edge E0 gives first beat out_valid=1 after edge E1.
REQ-026 Throughput: with out_ready held high, one beat per cycle and no bubbles.
REQ-027 DRAIN + out_ready=1 at an edge: out_valid<=0, out_last<=0, done<=1 for one cycle, busy<=0, go to IDLE.
REQ-028 A new start is accepted no earlier than the edge after done.
REQ-029 count=0 produces exactly one data beat, and that beat has out_last=1 (without CHECKSUM_EN).

Reset
REQ-030 rst=1 at an edge forces IDLE and clears these to 0: out_valid, out_last, out_data, done, busy, r_addr, remaining, checksum.
REQ-031 Reset mid-burst abandons the burst: no further beats and no done pulse; rst has priority over start.

Configuration
REQ-032 Macro MEM_STREAM_READER_CHECKSUM_EN controls an appended checksum beat.
REQ-033 With the macro defined: a DATA_W XOR accumulator runs over all data beats; CSUM loads one extra beat with out_data = XOR of the burst and out_last=1 (under the REQ-021 load condition), then goes to DRAIN. The accumulator clears on command accept.
REQ-034 Without the macro: no CSUM state, no accumulator, and a burst is exactly count+1 beats.

Verification
REQ-035 Memory 0..7 = 16'h1000+i; start_addr=2, count=3, out_ready=1 -> beats 1002,1003,1004,1005, last on 1005, first valid after E1, done one cycle after last accept.
REQ-036 start_addr=6, count=3 -> beats 1006,1007,1000,1001 (wrap).
REQ-037 Same burst with out_ready toggling 1,0,0,1,... -> payload held during stalls, no beat lost or duplicated, order preserved.
REQ-038 start pulsed during a burst -> ignored; a start on the edge after done -> accepted.
REQ-039 rst asserted after the second beat -> next cycle out_valid=0, busy=0, r_addr=0, and done never pulses.
REQ-040 CHECKSUM_EN, start_addr=0, count=1 -> beats 1000, 1001, then 0001 with last=1; count=0 -> beats 1000, then 1000 with last=1.
